// File: rtl/sensor_scan_pkg.sv
// Shared constants, state encoding and helpers for the sensor scanner.
package temp_scan_pkg;

  localparam int NUM_SENSORS = 5;
  localparam int TEMP_W      = 8;
  localparam int DATA_W      = NUM_SENSORS * TEMP_W;
  localparam int IDX_W       = 3;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_SELECT      = 3'd1,
    ST_WAIT_ACK    = 3'd2,
    ST_SHIFT       = 3'd3,
    ST_STORE       = 3'd4,
    ST_PUBLISH     = 3'd5,
    ST_WAIT_PERIOD = 3'd6
  } state_e;

  function automatic logic [NUM_SENSORS-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_SENSORS-1:0] oh;
    for (int k = 0; k < NUM_SENSORS; k++) begin
      oh[k] = (idx == IDX_W'(k));
    end
    return oh;
  endfunction

endpackage

// File: rtl/sensor_scan_if.sv
// Shared serial sensor bus: one-hot select, serial clock, ready and data lines.
interface sensor_scan_if;
  import temp_scan_pkg::*;

  logic [NUM_SENSORS-1:0] sens_sel_o;
  logic                   sens_sck_o;
  logic                   sens_ack_i;
  logic                   sens_sdo_i;

  modport master (output sens_sel_o, output sens_sck_o, input sens_ack_i, input sens_sdo_i);
  modport slave  (input sens_sel_o, input sens_sck_o, output sens_ack_i, output sens_sdo_i);

endinterface

// File: rtl/sensor_scan_sck_gen.sv
// Serial clock divider: sck toggles every SCK_DIV cycles while running and
// flags the cycle in which each rising/falling transition is being driven.
module sck_gen #(
  parameter int SCK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic run_i,
  input  logic clear_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CNT_W = (SCK_DIV > 1) ? $clog2(SCK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sck_q, sck_d;
  logic             tick;

  always_comb begin
    tick  = run_i && !clear_i && (cnt_q == CNT_W'(SCK_DIV - 1));
    cnt_d = cnt_q;
    sck_d = sck_q;
    if (clear_i) begin
      cnt_d = '0;
      sck_d = 1'b0;
    end else if (run_i) begin
      if (tick) begin
        cnt_d = '0;
        sck_d = ~sck_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign rise_o = tick && !sck_q;
  assign fall_o = tick && sck_q;

endmodule

// File: rtl/sensor_scan.sv
// Round-robin poller for five serial temperature sensors; assembles a frame in
// shadow registers and publishes data/enable atomically once per scan period.
module sensor_scan
  import temp_scan_pkg::*;
#(
  parameter int SCK_DIV     = 4,
  parameter int ACK_TIMEOUT = 16,
  parameter int SCAN_PERIOD = 1000
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   enable_i,
  input  logic [NUM_SENSORS-1:0] sens_mask_i,
  sensor_scan_if.master          sens,
  output logic [DATA_W-1:0]      sensors_data_o,
  output logic [NUM_SENSORS-1:0] sensors_en_o,
  output logic                   frame_valid_o,
  output logic                   busy_o,
  output logic [NUM_SENSORS-1:0] timeout_o
);

  localparam int TCNT_W = $clog2(ACK_TIMEOUT + 1);
  localparam int PER_W  = $clog2(SCAN_PERIOD + 1);

  state_e                              state_q, state_d;
  logic [IDX_W-1:0]                    idx_q, idx_d;
  logic [TCNT_W-1:0]                   tcnt_q, tcnt_d;
  logic [2:0]                          bitcnt_q, bitcnt_d;
  logic [TEMP_W-1:0]                   shift_q, shift_d;
  logic [NUM_SENSORS-1:0][TEMP_W-1:0]  shadow_data_q, shadow_data_d;
  logic [NUM_SENSORS-1:0]              shadow_en_q, shadow_en_d;
  logic [PER_W-1:0]                    period_q, period_d;
  logic [NUM_SENSORS-1:0]              sel_q, sel_d;
  logic [DATA_W-1:0]                   data_q, data_d;
  logic [NUM_SENSORS-1:0]              en_q, en_d;
  logic                                fv_q, fv_d;
  logic                                busy_q, busy_d;
  logic [NUM_SENSORS-1:0]              timeout_q, timeout_d;

  logic sck, rise, fall;

  sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .run_i   (state_q == ST_SHIFT),
    .clear_i (state_q != ST_SHIFT),
    .sck_o   (sck),
    .rise_o  (rise),
    .fall_o  (fall)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    tcnt_d        = tcnt_q;
    bitcnt_d      = bitcnt_q;
    shift_d       = shift_q;
    shadow_data_d = shadow_data_q;
    shadow_en_d   = shadow_en_q;
    sel_d         = sel_q;
    data_d        = data_q;
    en_d          = en_q;
    fv_d          = 1'b0;
    timeout_d     = timeout_q;
    period_d      = (period_q == PER_W'(SCAN_PERIOD)) ? period_q : period_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (enable_i) begin
          state_d  = ST_SELECT;
          idx_d    = '0;
          period_d = '0;
        end
      end
      ST_SELECT: begin
        if (!sens_mask_i[idx_q]) begin
          shadow_en_d[idx_q]   = 1'b0;
          shadow_data_d[idx_q] = '0;
          state_d              = ST_STORE;
        end else begin
          sel_d   = idx_onehot(idx_q);
          tcnt_d  = '0;
          state_d = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // A late ack on the final waiting cycle still wins over the timeout.
        if (sens.sens_ack_i) begin
          bitcnt_d = 3'd7;
          state_d  = ST_SHIFT;
        end else if (tcnt_q == TCNT_W'(ACK_TIMEOUT - 1)) begin
          shadow_en_d[idx_q]   = 1'b0;
          shadow_data_d[idx_q] = '0;
          timeout_d[idx_q]     = 1'b1;
          sel_d                = '0;
          state_d              = ST_STORE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (rise) begin
          shift_d = {shift_q[TEMP_W-2:0], sens.sens_sdo_i};
        end
        // Finish on the falling edge that follows the eighth sample.
        if (fall) begin
          if (bitcnt_q == 3'd0) begin
            shadow_en_d[idx_q]   = 1'b1;
            shadow_data_d[idx_q] = shift_q;
            sel_d                = '0;
            state_d              = ST_STORE;
          end else begin
            bitcnt_d = bitcnt_q - 1'b1;
          end
        end
      end
      ST_STORE: begin
        if (idx_q == IDX_W'(NUM_SENSORS - 1)) begin
          data_d  = shadow_data_q;
          en_d    = shadow_en_q;
          fv_d    = 1'b1;
          state_d = ST_PUBLISH;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = ST_SELECT;
        end
      end
      ST_PUBLISH: begin
        state_d = ST_WAIT_PERIOD;
      end
      ST_WAIT_PERIOD: begin
        if (!enable_i) begin
          state_d = ST_IDLE;
        end else if (period_q >= PER_W'(SCAN_PERIOD - 1)) begin
          state_d  = ST_SELECT;
          idx_d    = '0;
          period_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE) && (state_d != ST_WAIT_PERIOD);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      tcnt_q        <= '0;
      bitcnt_q      <= '0;
      shift_q       <= '0;
      shadow_data_q <= '0;
      shadow_en_q   <= '0;
      period_q      <= '0;
      sel_q         <= '0;
      data_q        <= '0;
      en_q          <= '0;
      fv_q          <= 1'b0;
      busy_q        <= 1'b0;
      timeout_q     <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      tcnt_q        <= tcnt_d;
      bitcnt_q      <= bitcnt_d;
      shift_q       <= shift_d;
      shadow_data_q <= shadow_data_d;
      shadow_en_q   <= shadow_en_d;
      period_q      <= period_d;
      sel_q         <= sel_d;
      data_q        <= data_d;
      en_q          <= en_d;
      fv_q          <= fv_d;
      busy_q        <= busy_d;
      timeout_q     <= timeout_d;
    end
  end

  assign sens.sens_sel_o = sel_q;
  assign sens.sens_sck_o = sck;
  assign sensors_data_o  = data_q;
  assign sensors_en_o    = en_q;
  assign frame_valid_o   = fv_q;
  assign busy_o          = busy_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_sensor_scan.sv
// Bench for sensor_scan: emulated sensors on the serial bus, a frame-level
// reference model and a per-cycle compare process.
module tb_sensor_scan;
  import temp_scan_pkg::*;

  localparam int SCK_DIV     = 4;
  localparam int ACK_TIMEOUT = 16;
  localparam int SCAN_PERIOD = 1000;

  logic                   clk    = 1'b0;
  logic                   rst_n  = 1'b1;
  logic                   enable = 1'b0;
  logic [NUM_SENSORS-1:0] mask   = '0;
  logic [DATA_W-1:0]      data_o;
  logic [NUM_SENSORS-1:0] en_o;
  logic [NUM_SENSORS-1:0] to_o;
  logic                   fv_o;
  logic                   busy_o;

  sensor_scan_if sif ();

  sensor_scan #(.SCK_DIV(SCK_DIV), .ACK_TIMEOUT(ACK_TIMEOUT), .SCAN_PERIOD(SCAN_PERIOD)) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .enable_i       (enable),
    .sens_mask_i    (mask),
    .sens           (sif.master),
    .sensors_data_o (data_o),
    .sensors_en_o   (en_o),
    .frame_valid_o  (fv_o),
    .busy_o         (busy_o),
    .timeout_o      (to_o)
  );

  always #5 clk = ~clk;

  // Sensor configuration: reading, ack latency and whether it never answers.
  logic [TEMP_W-1:0]      cfg_byte  [NUM_SENSORS];
  int                     cfg_delay [NUM_SENSORS];
  logic [NUM_SENSORS-1:0] cfg_dead = '0;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DATA_W-1:0] model_data();
    logic [DATA_W-1:0] d;
    d = '0;
    for (int k = 0; k < NUM_SENSORS; k++)
      if (mask[k] && !cfg_dead[k]) d[8*k +: 8] = cfg_byte[k];
    return d;
  endfunction

  function automatic logic [NUM_SENSORS-1:0] model_en();
    return mask & ~cfg_dead;
  endfunction

  // Emulated sensors: ack after a delay, shift MSB first, advance after each sck rise.
  int   sen_cnt  = 0;
  int   sen_rise = 0;
  logic sen_sck  = 1'b0;
  always @(negedge clk) begin
    int k;
    logic [TEMP_W-1:0] b;
    k = -1;
    for (int i = 0; i < NUM_SENSORS; i++) if (sif.sens_sel_o[i]) k = i;
    if (k < 0) begin
      sif.sens_ack_i = 1'b0;
      sif.sens_sdo_i = 1'b0;
      sen_cnt  = 0;
      sen_rise = 0;
      sen_sck  = 1'b0;
    end else begin
      if (sif.sens_sck_o && !sen_sck) sen_rise++;
      sen_sck = sif.sens_sck_o;
      sif.sens_ack_i = !cfg_dead[k] && (sen_cnt >= cfg_delay[k]);
      sen_cnt++;
      b = cfg_byte[k];
      sif.sens_sdo_i = (sen_rise < 8) ? b[7 - sen_rise] : 1'b0;
    end
  end

  // Compare process: published frame, bus legality, per-select episode shape.
  int                     cyc = 0, fv_cnt = 0, sel_events = 0;
  int                     start_cyc = -1, start_prev = -1;
  logic [DATA_W-1:0]      pub_data = '0;
  logic [NUM_SENSORS-1:0] pub_en = '0, exp_to = '0, sel_prev = '0;
  logic                   sck_prev = 1'b0, busy_prev = 1'b0;
  int                     ep_k = 0, ep_len = 0, ep_rise = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_data", 64'(data_o), 64'd0);
      chk("rst_en", 64'(en_o), 64'd0);
      chk("rst_timeout", 64'(to_o), 64'd0);
      chk("rst_sel", 64'(sif.sens_sel_o), 64'd0);
      pub_data  = '0;
      pub_en    = '0;
      exp_to    = '0;
      sel_prev  = '0;
      sck_prev  = 1'b0;
      busy_prev = 1'b0;
    end else begin
      if (fv_o) begin
        fv_cnt++;
        exp_to   = exp_to | (mask & cfg_dead);
        pub_data = model_data();
        pub_en   = model_en();
        chk("frame_timeout", 64'(to_o), 64'(exp_to));
      end
      chk("data", 64'(data_o), 64'(pub_data));
      chk("en", 64'(en_o), 64'(pub_en));
      chk("sel_onehot", 64'($onehot0(sif.sens_sel_o)), 64'd1);
      chk("sel_masked", 64'(sif.sens_sel_o & ~mask), 64'd0);
      if (sif.sens_sel_o == '0) chk("sck_idle", 64'(sif.sens_sck_o), 64'd0);

      if (sif.sens_sel_o != '0) begin
        if (sel_prev == '0) begin
          for (int i = 0; i < NUM_SENSORS; i++) if (sif.sens_sel_o[i]) ep_k = i;
          ep_len  = 0;
          ep_rise = 0;
          sel_events++;
        end
        ep_len++;
        if (sif.sens_sck_o && !sck_prev) ep_rise++;
      end else if (sel_prev != '0) begin
        if (cfg_dead[ep_k]) begin
          chk("sel_len_dead", 64'(ep_len), 64'(ACK_TIMEOUT));
          chk("sck_rises_dead", 64'(ep_rise), 64'd0);
        end else begin
          chk("sel_len", 64'(ep_len), 64'(cfg_delay[ep_k] + 1 + 16 * SCK_DIV));
          chk("sck_rises", 64'(ep_rise), 64'd8);
        end
      end
      if (busy_o && !busy_prev) begin
        start_prev = start_cyc;
        start_cyc  = cyc;
      end
      sel_prev  = sif.sens_sel_o;
      sck_prev  = sif.sens_sck_o;
      busy_prev = busy_o;
    end
  end

  task automatic wait_fv(input int budget);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (fv_o !== 1'b1 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("frame_valid_seen", 64'(fv_o), 64'd1);
    @(negedge clk); #1;
  endtask

  task automatic wait_sel(input int k, input logic need_sck, input int budget);
    int n;
    n = 0;
    while (!(sif.sens_sel_o[k] && (sif.sens_sck_o || !need_sck)) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    chk("sel_reached", 64'(sif.sens_sel_o[k]), 64'd1);
  endtask

  task automatic fixed_bytes();
    for (int k = 0; k < NUM_SENSORS; k++) begin
      cfg_byte[k]  = 8'(8'h19 + k);
      cfg_delay[k] = $urandom_range(0, 10);
    end
  endtask

  initial begin
    int f0, s0;
    fixed_bytes();
    mask = 5'h1F;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_fv", 64'(fv_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_sck", 64'(sif.sens_sck_o), 64'd0);
    @(posedge clk); #2;
    rst_n  = 1'b1;
    enable = 1'b1;

    // All five sensors present.
    wait_fv(3000);
    chk("t1_data", 64'(data_o), 64'h1D1C1B1A19);
    chk("t1_en", 64'(en_o), 64'h1F);

    mask = 5'b10101;
    wait_fv(3000);
    chk("t2_data", 64'(data_o), 64'h1D001B0019);
    chk("t2_en", 64'(en_o), 64'h15);
    chk("t2_period", 64'(start_cyc - start_prev), 64'(SCAN_PERIOD));

    // Sensor 2 never answers.
    mask = 5'h1F;
    cfg_dead = 5'b00100;
    wait_fv(3000);
    chk("t3_data", 64'(data_o), 64'h1D1C001A19);
    chk("t3_en", 64'(en_o), 64'h1B);
    chk("t3_timeout", 64'(to_o), 64'h04);

    // Randomised frames; the timeout of sensor 2 must stay latched.
    for (int f = 0; f < 4; f++) begin
      for (int k = 0; k < NUM_SENSORS; k++) begin
        cfg_byte[k]  = 8'($urandom_range(0, 255));
        cfg_delay[k] = $urandom_range(0, 10);
      end
      mask     = 5'($urandom_range(0, 31));
      cfg_dead = 5'($urandom_range(0, 31) & $urandom_range(0, 31));
      wait_fv(3000);
      chk("rand_period", 64'(start_cyc - start_prev), 64'(SCAN_PERIOD));
      chk("timeout2_sticky", 64'(to_o[2]), 64'd1);
      repeat (5) @(posedge clk);
      #1;
      chk("busy_wait_period", 64'(busy_o), 64'd0);
    end

    // Asynchronous reset in the middle of sensor 3's shift.
    mask     = 5'h1F;
    cfg_dead = '0;
    fixed_bytes();
    wait_sel(3, 1'b1, 3000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_data", 64'(data_o), 64'd0);
    chk("async_rst_en", 64'(en_o), 64'd0);
    chk("async_rst_timeout", 64'(to_o), 64'd0);
    chk("async_rst_sel", 64'(sif.sens_sel_o), 64'd0);
    chk("async_rst_sck", 64'(sif.sens_sck_o), 64'd0);
    chk("async_rst_busy", 64'(busy_o), 64'd0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    wait_fv(3000);
    chk("t5_data", 64'(data_o), 64'h1D1C1B1A19);
    chk("t5_en", 64'(en_o), 64'h1F);
    chk("t5_timeout", 64'(to_o), 64'd0);

    // Drop enable while sensor 1 is selected: frame finishes, then idle.
    wait_sel(1, 1'b0, 3000);
    enable = 1'b0;
    f0 = fv_cnt;
    wait_fv(3000);
    s0 = sel_events;
    repeat (1500) @(posedge clk);
    #1;
    chk("t6_one_publish", 64'(fv_cnt - f0), 64'd1);
    chk("t6_no_sel", 64'(sel_events - s0), 64'd0);
    chk("t6_idle_busy", 64'(busy_o), 64'd0);
    chk("t6_data", 64'(data_o), 64'h1D1C1B1A19);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
